// File: rtl/memory_arbiter_if.sv
// AXI4-Lite master bus between the arbiter (master) and the memory interconnect (slave).
// Plain signal bundle; all timing lives in the modules on either side.
interface memory_arbiter_if #(
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int AXI_DATA_WIDTH   = 32,
  parameter int AXI_STROBE_WIDTH = AXI_DATA_WIDTH / 8
);
  logic                        M_AXI_AWVALID;
  logic                        M_AXI_AWREADY;
  logic [AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR;
  logic [2:0]                  M_AXI_AWPROT;
  logic                        M_AXI_WVALID;
  logic                        M_AXI_WREADY;
  logic [AXI_DATA_WIDTH-1:0]   M_AXI_WDATA;
  logic [AXI_STROBE_WIDTH-1:0] M_AXI_WSTRB;
  logic                        M_AXI_BVALID;
  logic                        M_AXI_BREADY;
  logic [1:0]                  M_AXI_BRESP;
  logic                        M_AXI_ARVALID;
  logic                        M_AXI_ARREADY;
  logic [AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR;
  logic [2:0]                  M_AXI_ARPROT;
  logic                        M_AXI_RVALID;
  logic                        M_AXI_RREADY;
  logic [AXI_DATA_WIDTH-1:0]   M_AXI_RDATA;
  logic [1:0]                  M_AXI_RRESP;

  modport master (
    output M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_AWPROT,
    output M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB,
    output M_AXI_BREADY,
    output M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARPROT,
    output M_AXI_RREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BRESP,
    input  M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP
  );

  modport slave (
    input  M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_AWPROT,
    input  M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB,
    input  M_AXI_BREADY,
    input  M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARPROT,
    input  M_AXI_RREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BRESP,
    output M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP
  );
endinterface

// File: rtl/memory_arbiter.sv
// Muxes fetch/load/store onto one AXI4-Lite master, one transaction at a time; VALID one cycle after request.
// Backpressure: waits indefinitely on AXI READY/VALID; losing requesters wait with enables held.
module memory_arbiter #(
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int AXI_DATA_WIDTH   = 32,
  parameter int AXI_STROBE_WIDTH = AXI_DATA_WIDTH / 8
) (
  input  logic                        CLK,
  input  logic                        RSTn,
  memory_arbiter_if.master            axi,
  input  logic [AXI_ADDR_WIDTH-1:0]   pc,
  input  logic                        pc_valid,
  output logic [AXI_DATA_WIDTH-1:0]   instruction,
  output logic                        instruction_valid,
  input  logic [AXI_ADDR_WIDTH-1:0]   read_write_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   store_data,
  output logic [AXI_DATA_WIDTH-1:0]   load_data,
  input  logic                        read_enable,
  input  logic                        write_enable,
  input  logic [AXI_STROBE_WIDTH-1:0] store_strobe,
  output logic                        read_write_valid
);

  typedef enum logic [2:0] {
    IDLE, FETCH_AR, FETCH_R, LOAD_AR, LOAD_R, STORE_AW_W, STORE_B
  } state_t;

  state_t state;

  // A channel counts as done once its VALID has dropped or it handshakes this edge.
  logic aw_done;
  logic w_done;
  assign aw_done = !axi.M_AXI_AWVALID || axi.M_AXI_AWREADY;
  assign w_done  = !axi.M_AXI_WVALID  || axi.M_AXI_WREADY;

  // Response codes carry no meaning for the core; completion is reported regardless.
  logic unused_resp;
  assign unused_resp = ^{axi.M_AXI_RRESP, axi.M_AXI_BRESP};

  always_ff @(posedge CLK or posedge RSTn) begin
    if (RSTn) begin
      state             <= IDLE;
      axi.M_AXI_AWVALID <= 1'b0;
      axi.M_AXI_AWADDR  <= '0;
      axi.M_AXI_AWPROT  <= 3'b000;
      axi.M_AXI_WVALID  <= 1'b0;
      axi.M_AXI_WDATA   <= '0;
      axi.M_AXI_WSTRB   <= '0;
      axi.M_AXI_BREADY  <= 1'b0;
      axi.M_AXI_ARVALID <= 1'b0;
      axi.M_AXI_ARADDR  <= '0;
      axi.M_AXI_ARPROT  <= 3'b000;
      axi.M_AXI_RREADY  <= 1'b0;
      instruction       <= '0;
      instruction_valid <= 1'b0;
      load_data         <= '0;
      read_write_valid  <= 1'b0;
    end else begin
      instruction_valid <= 1'b0;
      read_write_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (write_enable) begin
            axi.M_AXI_AWADDR  <= read_write_addr;
            axi.M_AXI_AWPROT  <= 3'b000;
            axi.M_AXI_WDATA   <= store_data;
            axi.M_AXI_WSTRB   <= store_strobe;
            axi.M_AXI_AWVALID <= 1'b1;
            axi.M_AXI_WVALID  <= 1'b1;
            state             <= STORE_AW_W;
          end else if (read_enable) begin
            axi.M_AXI_ARADDR  <= read_write_addr;
            axi.M_AXI_ARPROT  <= 3'b000;
            axi.M_AXI_ARVALID <= 1'b1;
            state             <= LOAD_AR;
          end else if (pc_valid) begin
            axi.M_AXI_ARADDR  <= pc;
            axi.M_AXI_ARPROT  <= 3'b100;
            axi.M_AXI_ARVALID <= 1'b1;
            state             <= FETCH_AR;
          end
        end
        FETCH_AR, LOAD_AR: begin
          if (axi.M_AXI_ARVALID && axi.M_AXI_ARREADY) begin
            axi.M_AXI_ARVALID <= 1'b0;
            axi.M_AXI_RREADY  <= 1'b1;
            state             <= (state == FETCH_AR) ? FETCH_R : LOAD_R;
          end
        end
        FETCH_R: begin
          if (axi.M_AXI_RVALID && axi.M_AXI_RREADY) begin
            axi.M_AXI_RREADY  <= 1'b0;
            instruction       <= axi.M_AXI_RDATA;
            instruction_valid <= 1'b1;
            state             <= IDLE;
          end
        end
        LOAD_R: begin
          if (axi.M_AXI_RVALID && axi.M_AXI_RREADY) begin
            axi.M_AXI_RREADY <= 1'b0;
            load_data        <= axi.M_AXI_RDATA;
            read_write_valid <= 1'b1;
            state            <= IDLE;
          end
        end
        STORE_AW_W: begin
          if (axi.M_AXI_AWVALID && axi.M_AXI_AWREADY) axi.M_AXI_AWVALID <= 1'b0;
          if (axi.M_AXI_WVALID && axi.M_AXI_WREADY)   axi.M_AXI_WVALID  <= 1'b0;
          if (aw_done && w_done) begin
            axi.M_AXI_BREADY <= 1'b1;
            state            <= STORE_B;
          end
        end
        STORE_B: begin
          if (axi.M_AXI_BVALID && axi.M_AXI_BREADY) begin
            axi.M_AXI_BREADY <= 1'b0;
            read_write_valid <= 1'b1;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: scripted AXI slave responses, completions checked against a scoreboard.
module tb_memory_arbiter;
  logic        CLK = 1'b0;
  logic        RSTn;
  logic [31:0] pc, read_write_addr, store_data;
  logic        pc_valid, read_enable, write_enable;
  logic [3:0]  store_strobe;
  logic [31:0] instruction, load_data;
  logic        instruction_valid, read_write_valid;

  int total  = 0;
  int passes = 0;
  logic [31:0] exp_instr[$];
  logic [31:0] exp_load[$];
  int          exp_store = 0;
  logic [31:0] want;

  always #5 CLK = ~CLK;

  memory_arbiter_if axi();

  memory_arbiter dut (
    .CLK               (CLK),
    .RSTn              (RSTn),
    .axi               (axi),
    .pc                (pc),
    .pc_valid          (pc_valid),
    .instruction       (instruction),
    .instruction_valid (instruction_valid),
    .read_write_addr   (read_write_addr),
    .store_data        (store_data),
    .load_data         (load_data),
    .read_enable       (read_enable),
    .write_enable      (write_enable),
    .store_strobe      (store_strobe),
    .read_write_valid  (read_write_valid)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RSTn = 1'b1;
    pc = '0; pc_valid = 0; read_write_addr = '0; store_data = '0;
    read_enable = 0; write_enable = 0; store_strobe = '0;
    axi.M_AXI_AWREADY = 0; axi.M_AXI_WREADY = 0; axi.M_AXI_BVALID = 0; axi.M_AXI_BRESP = 2'b00;
    axi.M_AXI_ARREADY = 0; axi.M_AXI_RVALID = 0; axi.M_AXI_RDATA = '0; axi.M_AXI_RRESP = 2'b00;
    repeat (2) @(posedge CLK);
    #1 RSTn = 1'b0;
    step();
    total++; if (axi.M_AXI_ARVALID !== 1'b0) $display("FAIL rst_arvalid got %b want 0", axi.M_AXI_ARVALID); else passes++;
    total++; if (axi.M_AXI_AWVALID !== 1'b0) $display("FAIL rst_awvalid got %b want 0", axi.M_AXI_AWVALID); else passes++;
    total++; if (instruction_valid !== 1'b0) $display("FAIL rst_instr_valid got %b want 0", instruction_valid); else passes++;
    total++; if (read_write_valid !== 1'b0) $display("FAIL rst_rw_valid got %b want 0", read_write_valid); else passes++;
    total++; if ({axi.M_AXI_WVALID, axi.M_AXI_RREADY, axi.M_AXI_BREADY} !== 3'b000)
      $display("FAIL rst_w_r_b got %b want 000", {axi.M_AXI_WVALID, axi.M_AXI_RREADY, axi.M_AXI_BREADY}); else passes++;
    total++; if (instruction !== 32'h0) $display("FAIL rst_instruction got %h want 0", instruction); else passes++;
  endtask

  task automatic test_fetch();
    pc = 32'habac; pc_valid = 1;
    step();
    pc_valid = 0; pc = 32'hffff_fff0;
    total++; if (axi.M_AXI_ARVALID !== 1'b1) $display("FAIL fetch_arvalid got %b want 1", axi.M_AXI_ARVALID); else passes++;
    total++; if (axi.M_AXI_ARADDR !== 32'habac) $display("FAIL fetch_araddr got %h want 0000abac", axi.M_AXI_ARADDR); else passes++;
    total++; if (axi.M_AXI_ARPROT !== 3'b100) $display("FAIL fetch_arprot got %b want 100", axi.M_AXI_ARPROT); else passes++;
    step();
    total++; if (axi.M_AXI_ARVALID !== 1'b1 || axi.M_AXI_ARADDR !== 32'habac)
      $display("FAIL fetch_ar_hold got %b/%h want 1/0000abac", axi.M_AXI_ARVALID, axi.M_AXI_ARADDR); else passes++;
    axi.M_AXI_ARREADY = 1;
    step();
    axi.M_AXI_ARREADY = 0;
    total++; if ({axi.M_AXI_ARVALID, axi.M_AXI_RREADY} !== 2'b01)
      $display("FAIL fetch_ar_hs got %b want 01", {axi.M_AXI_ARVALID, axi.M_AXI_RREADY}); else passes++;
    axi.M_AXI_RVALID = 1; axi.M_AXI_RDATA = 32'hdeadaaaa; axi.M_AXI_RRESP = 2'b10;
    exp_instr.push_back(32'hdeadaaaa);
    step();
    axi.M_AXI_RVALID = 0; axi.M_AXI_RRESP = 2'b00; axi.M_AXI_RDATA = 32'h1111_1111;
    total++; if ({axi.M_AXI_RREADY, instruction_valid} !== 2'b01)
      $display("FAIL fetch_done got rready/ivalid %b want 01", {axi.M_AXI_RREADY, instruction_valid}); else passes++;
    want = (exp_instr.size() != 0) ? exp_instr.pop_front() : 32'hxxxxxxxx;
    total++; if (instruction !== want) $display("FAIL fetch_data got %h want %h", instruction, want); else passes++;
    step();
    total++; if (instruction_valid !== 1'b0 || instruction !== 32'hdeadaaaa)
      $display("FAIL fetch_pulse_hold got %b/%h want 0/deadaaaa", instruction_valid, instruction); else passes++;
    total++; if (axi.M_AXI_ARVALID !== 1'b0) $display("FAIL fetch_no_reissue got %b want 0", axi.M_AXI_ARVALID); else passes++;
  endtask

  task automatic test_store();
    write_enable = 1; read_write_addr = 32'h100; store_data = 32'h12345678; store_strobe = 4'b0011;
    step();
    write_enable = 0; read_write_addr = 32'h999; store_data = 32'h0; store_strobe = 4'b1111;
    total++; if ({axi.M_AXI_AWVALID, axi.M_AXI_WVALID} !== 2'b11)
      $display("FAIL st_valids got %b want 11", {axi.M_AXI_AWVALID, axi.M_AXI_WVALID}); else passes++;
    total++; if (axi.M_AXI_AWADDR !== 32'h100 || axi.M_AXI_AWPROT !== 3'b000)
      $display("FAIL st_awaddr got %h/%b want 00000100/000", axi.M_AXI_AWADDR, axi.M_AXI_AWPROT); else passes++;
    total++; if (axi.M_AXI_WDATA !== 32'h12345678 || axi.M_AXI_WSTRB !== 4'b0011)
      $display("FAIL st_wdata got %h/%b want 12345678/0011", axi.M_AXI_WDATA, axi.M_AXI_WSTRB); else passes++;
    axi.M_AXI_AWREADY = 1;
    step();
    axi.M_AXI_AWREADY = 0;
    total++; if ({axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY} !== 3'b010)
      $display("FAIL st_aw_first got aw/w/b %b want 010", {axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY}); else passes++;
    axi.M_AXI_WREADY = 1;
    step();
    axi.M_AXI_WREADY = 0;
    total++; if ({axi.M_AXI_WVALID, axi.M_AXI_BREADY} !== 2'b01)
      $display("FAIL st_w_done got w/b %b want 01", {axi.M_AXI_WVALID, axi.M_AXI_BREADY}); else passes++;
    axi.M_AXI_BVALID = 1; axi.M_AXI_BRESP = 2'b11;
    exp_store++;
    step();
    axi.M_AXI_BVALID = 0; axi.M_AXI_BRESP = 2'b00;
    total++; if (read_write_valid !== (exp_store > 0) || axi.M_AXI_BREADY !== 1'b0)
      $display("FAIL st_done got rwv/bready %b/%b want 1/0", read_write_valid, axi.M_AXI_BREADY); else passes++;
    if (read_write_valid === 1'b1 && exp_store > 0) exp_store--;
    step();
    total++; if (read_write_valid !== 1'b0) $display("FAIL st_pulse got %b want 0", read_write_valid); else passes++;
  endtask

  task automatic test_arbitration();
    int waited;
    read_enable = 1; pc_valid = 1; read_write_addr = 32'h200; pc = 32'h0;
    step();
    read_enable = 0;
    total++; if (axi.M_AXI_ARADDR !== 32'h200 || axi.M_AXI_ARPROT !== 3'b000 || axi.M_AXI_ARVALID !== 1'b1)
      $display("FAIL arb_load_first got %b/%h/%b want 1/00000200/000",
               axi.M_AXI_ARVALID, axi.M_AXI_ARADDR, axi.M_AXI_ARPROT); else passes++;
    axi.M_AXI_ARREADY = 1;
    step();
    axi.M_AXI_ARREADY = 0;
    axi.M_AXI_RVALID = 1; axi.M_AXI_RDATA = 32'hcafef00d;
    exp_load.push_back(32'hcafef00d);
    step();
    axi.M_AXI_RVALID = 0;
    want = (exp_load.size() != 0) ? exp_load.pop_front() : 32'hxxxxxxxx;
    total++; if (read_write_valid !== 1'b1 || instruction_valid !== 1'b0 || load_data !== want)
      $display("FAIL arb_load_done got rwv/iv/data %b/%b/%h want 1/0/%h",
               read_write_valid, instruction_valid, load_data, want); else passes++;
    waited = 0;
    while (axi.M_AXI_ARVALID !== 1'b1 && waited < 10) begin
      step();
      waited++;
    end
    pc_valid = 0;
    total++; if (waited != 1 || axi.M_AXI_ARADDR !== 32'h0 || axi.M_AXI_ARPROT !== 3'b100)
      $display("FAIL arb_fetch_next got wait/addr/prot %0d/%h/%b want 1/00000000/100",
               waited, axi.M_AXI_ARADDR, axi.M_AXI_ARPROT); else passes++;
    axi.M_AXI_ARREADY = 1;
    step();
    axi.M_AXI_ARREADY = 0;
    axi.M_AXI_RVALID = 1; axi.M_AXI_RDATA = 32'h00000013;
    exp_instr.push_back(32'h00000013);
    step();
    axi.M_AXI_RVALID = 0;
    want = (exp_instr.size() != 0) ? exp_instr.pop_front() : 32'hxxxxxxxx;
    total++; if (instruction_valid !== 1'b1 || instruction !== want || load_data !== 32'hcafef00d)
      $display("FAIL arb_fetch_done got iv/instr/load %b/%h/%h want 1/%h/cafef00d",
               instruction_valid, instruction, load_data, want); else passes++;
    step();
  endtask

  task automatic test_back_to_back();
    write_enable = 1; read_enable = 1; read_write_addr = 32'h300;
    store_data = 32'ha5a5a5a5; store_strobe = 4'b1111;
    step();
    write_enable = 0;
    total++; if ({axi.M_AXI_AWVALID, axi.M_AXI_ARVALID} !== 2'b10)
      $display("FAIL b2b_store_prio got aw/ar %b want 10", {axi.M_AXI_AWVALID, axi.M_AXI_ARVALID}); else passes++;
    axi.M_AXI_AWREADY = 1; axi.M_AXI_WREADY = 1;
    step();
    axi.M_AXI_AWREADY = 0; axi.M_AXI_WREADY = 0;
    total++; if ({axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY} !== 3'b001)
      $display("FAIL b2b_aw_w_same got aw/w/b %b want 001", {axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY}); else passes++;
    axi.M_AXI_BVALID = 1;
    exp_store++;
    step();
    axi.M_AXI_BVALID = 0;
    total++; if (read_write_valid !== (exp_store > 0)) $display("FAIL b2b_store_done got %b want 1", read_write_valid); else passes++;
    if (read_write_valid === 1'b1 && exp_store > 0) exp_store--;
    step();
    read_enable = 0;
    total++; if (axi.M_AXI_ARVALID !== 1'b1 || axi.M_AXI_ARADDR !== 32'h300 || axi.M_AXI_ARPROT !== 3'b000)
      $display("FAIL b2b_load_issue got %b/%h/%b want 1/00000300/000",
               axi.M_AXI_ARVALID, axi.M_AXI_ARADDR, axi.M_AXI_ARPROT); else passes++;
    axi.M_AXI_ARREADY = 1;
    step();
    axi.M_AXI_ARREADY = 0;
    axi.M_AXI_RVALID = 1; axi.M_AXI_RDATA = 32'h0badf00d;
    exp_load.push_back(32'h0badf00d);
    step();
    axi.M_AXI_RVALID = 0;
    want = (exp_load.size() != 0) ? exp_load.pop_front() : 32'hxxxxxxxx;
    total++; if (read_write_valid !== 1'b1 || load_data !== want || instruction !== 32'h00000013)
      $display("FAIL b2b_load_done got rwv/load/instr %b/%h/%h want 1/%h/00000013",
               read_write_valid, load_data, instruction, want); else passes++;
    step();
  endtask

  task automatic test_reset_mid();
    pc = 32'h40; pc_valid = 1;
    step();
    pc_valid = 0;
    axi.M_AXI_ARREADY = 1;
    step();
    axi.M_AXI_ARREADY = 0;
    axi.M_AXI_RVALID = 1; axi.M_AXI_RDATA = 32'h77;
    RSTn = 1'b1;
    #1;
    total++; if (axi.M_AXI_RREADY !== 1'b0 || instruction !== 32'h0 || load_data !== 32'h0)
      $display("FAIL mid_rst_async got rready/instr/load %b/%h/%h want 0/0/0",
               axi.M_AXI_RREADY, instruction, load_data); else passes++;
    step();
    axi.M_AXI_RVALID = 0;
    RSTn = 1'b0;
    step();
    total++; if ({instruction_valid, read_write_valid, axi.M_AXI_ARVALID} !== 3'b000)
      $display("FAIL mid_rst_no_pulse got iv/rwv/ar %b want 000",
               {instruction_valid, read_write_valid, axi.M_AXI_ARVALID}); else passes++;
    total++; if (exp_instr.size() != 0 || exp_load.size() != 0 || exp_store != 0)
      $display("FAIL scoreboard_left got %0d/%0d/%0d want 0/0/0", exp_instr.size(), exp_load.size(), exp_store); else passes++;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_arbitration();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got timeout want completion (%0d/%0d so far)", passes, total);
    $fatal(1, "watchdog expired");
  end
endmodule
